time_set_ctrl: RTL

//   Button-driven time-setting controller; writer side of the hour/minute

---
 rtl/time_set_ctrl_if.sv | 22 ++
 rtl/time_set_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// Load/key interface between the time-setting controller and its surroundings.
// Carries raw keys, live BCD time in, and Status/preset/blink out.
interface time_set_ctrl_if;
    logic       key_mode_n;
    logic       key_up_n;
    logic [7:0] curHour;
    logic [7:0] curMin;
    logic [3:0] Status;
    logic [7:0] newHour;
    logic [7:0] newMin;
    logic       blink;

    modport master (
        output key_mode_n, key_up_n, curHour, curMin,
        input  Status, newHour, newMin, blink
    );

    modport slave (
        input  key_mode_n, key_up_n, curHour, curMin,
        output Status, newHour, newMin, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: debounced mode/up keys step a
// RUN -> SET_HOUR -> SET_MIN cycle and edit BCD presets for the counters.
//
// state    | meaning
// RUN      | clock running, presets held, blink off
// SET_HOUR | editing newHour, loaded by the hour counter
// SET_MIN  | editing newMin, loaded by the minute counter
module time_set_ctrl #(
    parameter int DEB_CYCLES = 20,
    parameter int BLINK_HALF = 6_000_000
) (
    input  logic              clk,
    input  logic              nCR,
    time_set_ctrl_if.slave    bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      hour, hour_nx, min, min_nx;
    logic            blink, blink_nx;
    logic [BW-1:0]   bcnt, bcnt_nx;

    // index 0 = mode key, index 1 = up key
    logic [1:0]      sync1, sync2, deb, press;
    logic [DW-1:0]   dcnt [2];

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            press <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= {bus.key_up_n, bus.key_mode_n};
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb[i]   <= sync2[i];
                    dcnt[i]  <= '0;
                    press[i] <= ~sync2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)            return 8'h00;
        else if (v[3:0] == 4'd9) return {4'(v[7:4] + 4'd1), 4'h0};
        else                     return {v[7:4], 4'(v[3:0] + 4'd1)};
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && ((v[7:4] < 4'd2) || (v[7:4] == 4'd2 && v[3:0] <= 4'd3));
    endfunction

    function automatic logic min_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            state <= RUN;
            hour  <= 8'h00;
            min   <= 8'h00;
            blink <= 1'b0;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            hour  <= hour_nx;
            min   <= min_nx;
            blink <= blink_nx;
            bcnt  <= bcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hour_nx  = hour;
        min_nx   = min;
        blink_nx = blink;
        bcnt_nx  = '0;
        // mode has priority; a simultaneous up pulse is dropped
        if (press[0]) begin
            blink_nx = 1'b1;
            case (state)
                RUN: begin
                    state_nx = SET_HOUR;
                    hour_nx  = hour_ok(bus.curHour) ? bus.curHour : 8'h00;
                    min_nx   = min_ok(bus.curMin)   ? bus.curMin  : 8'h00;
                end
                SET_HOUR: state_nx = SET_MIN;
                default: begin
                    state_nx = RUN;
                    blink_nx = 1'b0;
                end
            endcase
        end else if (state == RUN) begin
            blink_nx = 1'b0;
        end else if (press[1]) begin
            blink_nx = 1'b1;
            if (state == SET_HOUR) hour_nx = bcd_inc(hour, 8'h23);
            else                   min_nx  = bcd_inc(min, 8'h59);
        end else if (bcnt == BW'(BLINK_HALF - 1)) begin
            blink_nx = ~blink;
        end else begin
            bcnt_nx = bcnt + 1'b1;
        end
    end

    assign bus.Status  = {2'b00, state};
    assign bus.newHour = hour;
    assign bus.newMin  = min;
    assign bus.blink   = blink;
endmodule
